// File: rtl/ex_muldiv_unit_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit.
// funct3 operation codes, FSM states and operand-signedness helpers.
package ex_muldiv_unit_pkg;

    typedef enum logic [2:0] {
        MULDIV_MUL    = 3'd0,
        MULDIV_MULH   = 3'd1,
        MULDIV_MULHSU = 3'd2,
        MULDIV_MULHU  = 3'd3,
        MULDIV_DIV    = 3'd4,
        MULDIV_DIVU   = 3'd5,
        MULDIV_REM    = 3'd6,
        MULDIV_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_e;

    // MUL produces only the low half, so it is run unsigned.
    function automatic logic op_a_signed(input logic [2:0] op);
        return (op == MULDIV_MULH) || (op == MULDIV_MULHSU) ||
               (op == MULDIV_DIV)  || (op == MULDIV_REM);
    endfunction

    function automatic logic op_b_signed(input logic [2:0] op);
        return (op == MULDIV_MULH) || (op == MULDIV_DIV) || (op == MULDIV_REM);
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational sign handling: operand magnitudes on entry, two's complement
// negation of the raw 2*XLEN result on exit.
module muldiv_sign_fix #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    input  logic              a_signed,
    input  logic              b_signed,
    output logic [XLEN-1:0]   a_mag,
    output logic [XLEN-1:0]   b_mag,
    output logic              a_neg,
    output logic              b_neg,
    input  logic [2*XLEN-1:0] res_raw,
    input  logic              res_neg,
    output logic [2*XLEN-1:0] res_fixed
);

    always_comb begin
        a_neg     = a_signed & a[XLEN-1];
        b_neg     = b_signed & b[XLEN-1];
        a_mag     = a_neg ? (~a + 1'b1) : a;
        b_mag     = b_neg ? (~b + 1'b1) : b;
        res_fixed = res_neg ? (~res_raw + 1'b1) : res_raw;
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Radix-2 iterative RV32M multiply/divide for the EX stage; XLEN+1 cycles to
// done, special divide cases finish one cycle after acceptance.
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] result,
    output logic            done,
    output logic            busy,
    output logic            stall_req
);

    muldiv_state_e    state_q, state_d;
    muldiv_op_e       op_q, op_d;
    logic [XLEN-1:0]  b_q, b_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN:0]    rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic             done_q, done_d;

    logic [XLEN-1:0]   a_mag, b_mag;
    logic              a_neg, b_neg;
    logic [2*XLEN-1:0] fix_raw, fix_out;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next, div_acc_next, acc_calc;
    logic [XLEN:0]     div_shift, div_diff, div_rem_next, rem_calc;
    logic              div_ge, is_div, in_div, in_rem;
    logic [XLEN-1:0]   final_sel;

    muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
        .a         (rs1_data),
        .b         (rs2_data),
        .a_signed  (op_a_signed(op)),
        .b_signed  (op_b_signed(op)),
        .a_mag     (a_mag),
        .b_mag     (b_mag),
        .a_neg     (a_neg),
        .b_neg     (b_neg),
        .res_raw   (fix_raw),
        .res_neg   (neg_q),
        .res_fixed (fix_out)
    );

    always_comb begin
        // Multiply: multiplier sits in acc low half, product shifts in from the top.
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};

        // Divide: dividend shifts out of acc low half, quotient bits shift in.
        div_shift    = {rem_q[XLEN-1:0], acc_q[XLEN-1]};
        div_diff     = div_shift - {1'b0, b_q};
        div_ge       = ~div_diff[XLEN];
        div_rem_next = div_ge ? div_diff : div_shift;
        div_acc_next = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], div_ge};

        is_div   = op_q[2];
        acc_calc = is_div ? div_acc_next : mul_next;
        rem_calc = is_div ? div_rem_next : rem_q;

        if (!is_div)
            fix_raw = acc_calc;
        else if (op_q[1])
            fix_raw = {{XLEN{1'b0}}, rem_calc[XLEN-1:0]};
        else
            fix_raw = {{XLEN{1'b0}}, acc_calc[XLEN-1:0]};

        final_sel = (op_q == MULDIV_MUL || is_div) ? fix_out[XLEN-1:0]
                                                   : fix_out[2*XLEN-1:XLEN];

        in_div = op[2];
        in_rem = op[2] & op[1];

        state_d  = state_q;
        op_d     = op_q;
        b_d      = b_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        result_d = result_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    op_d  = muldiv_op_e'(op);
                    b_d   = b_mag;
                    acc_d = {{XLEN{1'b0}}, a_mag};
                    rem_d = '0;
                    cnt_d = CNT_W'(XLEN);
                    neg_d = in_rem ? a_neg : (a_neg ^ b_neg);
                    if (in_div && rs2_data == '0) begin
                        result_d = in_rem ? rs1_data : '1;
                        done_d   = 1'b1;
                        state_d  = ST_DONE;
                    end else if (in_div && !op[0] &&
                                 rs1_data == {1'b1, {(XLEN-1){1'b0}}} &&
                                 rs2_data == '1) begin
                        result_d = in_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                        done_d   = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = acc_calc;
                    rem_d = rem_calc;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        result_d = final_sel;
                        done_d   = 1'b1;
                        state_d  = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= MULDIV_MUL;
            b_q      <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign result    = result_q;
    assign done      = done_q & ~flush;
    assign busy      = (state_q != ST_IDLE);
    assign stall_req = (state_q == ST_IDLE && start && !flush) || (state_q == ST_CALC);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs1_data, rs2_data;
    logic [31:0] result;
    logic        done, busy, stall_req;

    int tests  = 0;
    int failed = 0;

    ex_muldiv_unit dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .start     (start),
        .op        (op),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .result    (result),
        .done      (done),
        .busy      (busy),
        .stall_req (stall_req)
    );

    always #5 clk = ~clk;

    // Launches one op, holds start until done is seen; lat = cycles after acceptance cycle.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] res);
        @(posedge clk); #1;
        op = o; rs1_data = a; rs2_data = b; start = 1'b1;
        lat = -1; res = 32'hDEAD_BEEF;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k; res = result;
                break;
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; start = 1'b0; op = 3'd0; rs1_data = '0; rs2_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        tests++;
        if (result !== 32'h0 || done !== 1'b0 || busy !== 1'b0 || stall_req !== 1'b0) begin
            failed++;
            $display("FAIL reset: result=%h done=%b busy=%b stall=%b want 0/0/0/0",
                     result, done, busy, stall_req);
        end
    endtask

    task automatic test_mul_timing();
        logic exp_stall, exp_done;
        @(posedge clk); #1;
        op = 3'd0; rs1_data = 32'd7; rs2_data = 32'hFFFF_FFFD; start = 1'b1;
        for (int k = 0; k <= 34; k++) begin
            @(negedge clk);
            exp_stall = (k <= 32);
            exp_done  = (k == 33);
            tests++;
            if (stall_req !== exp_stall || done !== exp_done) begin
                failed++;
                $display("FAIL mul_timing cycle T+%0d: stall=%b done=%b want %b/%b",
                         k, stall_req, done, exp_stall, exp_done);
            end
            if (k == 33) begin
                tests++;
                if (result !== 32'hFFFF_FFEB) begin
                    failed++;
                    $display("FAIL mul_result: got %h want ffffffeb", result);
                end
            end
            @(posedge clk); #1;
            if (k >= 33) start = 1'b0;
        end
    endtask

    task automatic test_mul_high();
        int lat; logic [31:0] res;
        issue(3'd1, 32'h8000_0000, 32'h8000_0000, lat, res);
        tests++;
        if (res !== 32'h4000_0000 || lat != 33) begin
            failed++; $display("FAIL mulh: got %h lat %0d want 40000000 lat 33", res, lat);
        end
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res);
        tests++;
        if (res !== 32'hFFFF_FFFE || lat != 33) begin
            failed++; $display("FAIL mulhu: got %h lat %0d want fffffffe lat 33", res, lat);
        end
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res);
        tests++;
        if (res !== 32'hFFFF_FFFF || lat != 33) begin
            failed++; $display("FAIL mulhsu: got %h lat %0d want ffffffff lat 33", res, lat);
        end
    endtask

    task automatic test_div_signed();
        int lat; logic [31:0] res;
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, lat, res);
        tests++;
        if (res !== 32'hFFFF_FFFD || lat != 33) begin
            failed++; $display("FAIL div_neg: got %h lat %0d want fffffffd lat 33", res, lat);
        end
        issue(3'd6, 32'hFFFF_FFF9, 32'd2, lat, res);
        tests++;
        if (res !== 32'hFFFF_FFFF || lat != 33) begin
            failed++; $display("FAIL rem_neg: got %h lat %0d want ffffffff lat 33", res, lat);
        end
    endtask

    task automatic test_special_cases();
        int lat; logic [31:0] res;
        issue(3'd5, 32'd5, 32'd0, lat, res);
        tests++;
        if (res !== 32'hFFFF_FFFF || lat != 1) begin
            failed++; $display("FAIL divu_by_zero: got %h lat %0d want ffffffff lat 1", res, lat);
        end
        issue(3'd7, 32'd5, 32'd0, lat, res);
        tests++;
        if (res !== 32'd5 || lat != 1) begin
            failed++; $display("FAIL remu_by_zero: got %h lat %0d want 00000005 lat 1", res, lat);
        end
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, lat, res);
        tests++;
        if (res !== 32'h8000_0000 || lat != 1) begin
            failed++; $display("FAIL div_overflow: got %h lat %0d want 80000000 lat 1", res, lat);
        end
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, lat, res);
        tests++;
        if (res !== 32'h0 || lat != 1) begin
            failed++; $display("FAIL rem_overflow: got %h lat %0d want 00000000 lat 1", res, lat);
        end
    endtask

    task automatic test_flush();
        int lat; logic [31:0] res;
        int bad;
        @(posedge clk); #1;
        op = 3'd5; rs1_data = 32'd100; rs2_data = 32'd7; start = 1'b1;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1; start = 1'b0;
        @(posedge clk); #1 flush = 1'b0;
        bad = 0;
        for (int k = 11; k < 46; k++) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            failed++; $display("FAIL flush_quiet: %0d cycles with busy/done set, want 0", bad);
        end
        issue(3'd5, 32'd100, 32'd7, lat, res);
        tests++;
        if (res !== 32'd14 || lat != 33) begin
            failed++; $display("FAIL divu_after_flush: got %h lat %0d want 0000000e lat 33", res, lat);
        end
    endtask

    task automatic test_reset_mid_calc();
        @(posedge clk); #1;
        op = 3'd4; rs1_data = 32'd1000; rs2_data = 32'd3; start = 1'b1;
        repeat (5) @(posedge clk);
        #1 start = 1'b0; rst = 1'b1;
        @(negedge clk);
        tests++;
        if (busy !== 1'b1) begin
            failed++; $display("FAIL busy_before_rst: got %b want 1", busy);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        tests++;
        if (result !== 32'h0 || done !== 1'b0 || busy !== 1'b0 || stall_req !== 1'b0) begin
            failed++;
            $display("FAIL rst_mid_calc: result=%h done=%b busy=%b stall=%b want 0/0/0/0",
                     result, done, busy, stall_req);
        end
    endtask

    initial begin
        test_reset();
        test_mul_timing();
        test_mul_high();
        test_div_signed();
        test_special_cases();
        test_flush();
        test_reset_mid_calc();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage.
- Consumes the forwarded EX operands (rs1/rs2 data after forwarding) and produces a result for the EX/ME register.
- Holds the pipeline through a stall request until the result is ready.
- Radix-2: one bit per cycle; divide-by-zero and signed overflow resolve early.

Parameters:
XLEN, 32, operand/result width (equals DATA_WIDTH)
CNT_W, $clog2(XLEN)+1, iteration counter width

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
flush  in  1  kill in-flight op (branch mispredict/trap)
start  in  1  EX holds a valid M-extension instruction
op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
rs1_data  in  XLEN  forwarded operand A
rs2_data  in  XLEN  forwarded operand B
result  out  XLEN  final result, valid when done=1
done  out  1  one-cycle completion pulse
busy  out  1  state != IDLE
stall_req  out  1  to hazard unit: freeze PC, IF/ID and ID/EX; bubble into EX/ME

Behaviour:
- Reset (sync, rst=1 at posedge):
  - state=IDLE; result=0, done=0, busy=0.
  - Counter and internal registers cleared.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - start=1 (cycle T): latch op, operands and sign info.
  - Take magnitudes of signed operands (MULH/MULHSU/DIV/REM per RISC-V rules); load counter=XLEN.
  - Go to CALC; if a special case applies, go directly to DONE.
- CALC:
  - MUL*: shift-add into a 2*XLEN accumulator.
  - DIV*/REM*: restoring subtract/shift.
  - Counter decrements each cycle; at counter==1 go to DONE.
  - Exactly XLEN CALC cycles (T+1..T+XLEN).
- DONE (T+XLEN+1):
  - Apply sign correction; register result; done=1 for this cycle only; next state IDLE.
  - result holds its value until the next accepted start.
- Result selection:
  - MUL: low XLEN bits.
  - MULH/MULHSU/MULHU: high XLEN bits.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
  - Quotient sign = sA xor sB; remainder sign = sA.
- Special cases (DONE at T+1, no CALC):
  - Divisor 0: DIV/DIVU -> all ones; REM/REMU -> rs1_data.
  - DIV with rs1=0x80000000, rs2=0xFFFFFFFF: quotient=0x80000000; REM -> 0.
- stall_req (combinational):
  - = (state==IDLE && start && !flush) || state==CALC.
  - Low in DONE so EX advances with result in the same cycle.
- start while busy: ignored.
  - The held ID/EX stage keeps start asserted; the unit recognises it only in IDLE.
  - After DONE, one IDLE cycle occurs before the next acceptance.
- flush:
  - In CALC or DONE: next state IDLE; done forced 0 that cycle; result unchanged.
  - In IDLE together with start: start is not accepted.
- rst has priority over flush and start at any state, including mid-CALC.
- Internal arithmetic widths:
  - Accumulator 2*XLEN.
  - Divider partial remainder XLEN+1 bits.
  - Negation in two's complement mod 2^XLEN.

Decomposition:
- Defines.vh holds the funct3 encodings (MULDIV_MUL..MULDIV_REMU) and the FSM state encodings (2-bit).
- One sub-module, muldiv_sign_fix:
  - Combinational.
  - Operand magnitude extraction and final result negation.
  - Shared by the pre-step and the DONE step.
- Iteration datapath stays in ex_muldiv_unit.

Test Plan:
- MUL 7 x 0xFFFFFFFD (-3), start at T:
  - stall_req high T..T+32; done=1 at T+33 only; result=0xFFFFFFEB.
- MULH 0x80000000 x 0x80000000 -> 0x40000000.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF.
- DIVU 5 / 0 -> 0xFFFFFFFF at T+1; REMU 5 / 0 -> 5 at T+1.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at T+1; REM -> 0.
- Flush and reset:
  - DIVU 100/7 started, flush at T+10: busy=0 and no done from T+11.
  - A new start DIVU 100/7 -> 14 after 33 cycles.
  - rst asserted mid-CALC -> all outputs 0 next cycle.
